// File: rtl/cpu_defs.sv
// Shared constants for the MIPS pipeline: instruction width and fetch-stage defaults.
package cpu_defs;

   localparam int unsigned INST_W = 32;

   localparam logic [INST_W-1:0] NOP_INST   = 32'h0000_0000;
   localparam logic [INST_W-1:0] RESET_PC   = 32'h0000_0000;
   localparam logic [INST_W-1:0] EXC_VECTOR = 32'h8000_0008;

   // Redirect targets are word aligned; low address bits are discarded.
   function automatic logic [INST_W-1:0] align_word(input logic [INST_W-1:0] addr);
      return {addr[INST_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: reset, exception, branch, jump, stall-hold, then sequential pc+4.
module pc_next_sel #(
   parameter logic [cpu_defs::INST_W-1:0] RESET_PC   = cpu_defs::RESET_PC,
   parameter logic [cpu_defs::INST_W-1:0] EXC_VECTOR = cpu_defs::EXC_VECTOR
) (
   input  logic                        reset,
   input  logic                        exception,
   input  logic                        branch_taken,
   input  logic [cpu_defs::INST_W-1:0] branch_target,
   input  logic                        jump,
   input  logic [cpu_defs::INST_W-1:0] jump_target,
   input  logic                        stall,
   input  logic [cpu_defs::INST_W-1:0] pc,
   output logic [cpu_defs::INST_W-1:0] pc_plus4,
   output logic [cpu_defs::INST_W-1:0] next_pc,
   output logic                        redirect
);
   import cpu_defs::*;

   // Modulo-2^32 increment, so the top word wraps to zero.
   assign pc_plus4 = pc + 32'd4;
   assign redirect = exception | branch_taken | jump;

   always_comb begin
      next_pc = pc_plus4;
      if (reset) begin
         next_pc = RESET_PC;
      end else if (exception) begin
         next_pc = align_word(EXC_VECTOR);
      end else if (branch_taken) begin
         next_pc = align_word(branch_target);
      end else if (jump) begin
         next_pc = align_word(jump_target);
      end else if (stall) begin
         next_pc = pc;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses the instruction ROM and loads the IF/ID register.
module fetch_stage #(
   parameter logic [cpu_defs::INST_W-1:0] RESET_PC   = cpu_defs::RESET_PC,
   parameter logic [cpu_defs::INST_W-1:0] EXC_VECTOR = cpu_defs::EXC_VECTOR,
   parameter logic [cpu_defs::INST_W-1:0] NOP_INST   = cpu_defs::NOP_INST
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        stall,
   input  logic                        flush,
   input  logic                        branch_taken,
   input  logic [cpu_defs::INST_W-1:0] branch_target,
   input  logic                        jump,
   input  logic [cpu_defs::INST_W-1:0] jump_target,
   input  logic                        exception,
   output logic [cpu_defs::INST_W-1:0] inst_addr,
   input  logic [cpu_defs::INST_W-1:0] inst_data,
   output logic [cpu_defs::INST_W-1:0] pc,
   output logic [cpu_defs::INST_W-1:0] id_instruction,
   output logic [cpu_defs::INST_W-1:0] id_pc_plus4,
   output logic                        id_valid
);
   import cpu_defs::*;

   logic [INST_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] id_inst_q, id_inst_d;
   logic [INST_W-1:0] id_pc4_q, id_pc4_d;
   logic              id_valid_q, id_valid_d;
   logic [INST_W-1:0] pc_plus4;
   logic              redirect;

   pc_next_sel #(
      .RESET_PC   (RESET_PC),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_pc_next_sel (
      .reset         (reset),
      .exception     (exception),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .stall         (stall),
      .pc            (pc_q),
      .pc_plus4      (pc_plus4),
      .next_pc       (pc_d),
      .redirect      (redirect)
   );

   // No delay slots: any redirect squashes the instruction fetched this cycle.
   always_comb begin
      id_inst_d  = inst_data;
      id_pc4_d   = pc_plus4;
      id_valid_d = 1'b1;
      if (redirect || flush) begin
         id_inst_d  = NOP_INST;
         id_pc4_d   = '0;
         id_valid_d = 1'b0;
      end else if (stall) begin
         id_inst_d  = id_inst_q;
         id_pc4_d   = id_pc4_q;
         id_valid_d = id_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         id_inst_q  <= NOP_INST;
         id_pc4_q   <= '0;
         id_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         id_inst_q  <= id_inst_d;
         id_pc4_q   <= id_pc4_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign inst_addr      = pc_q;
   assign pc             = pc_q;
   assign id_instruction = id_inst_q;
   assign id_pc_plus4    = id_pc4_q;
   assign id_valid       = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction ROM model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush, branch_taken, jump, exception;
   logic [31:0] branch_target, jump_target;
   logic [31:0] inst_addr, inst_data, pc, id_instruction, id_pc_plus4;
   logic        id_valid;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump           (jump),
      .jump_target    (jump_target),
      .exception      (exception),
      .inst_addr      (inst_addr),
      .inst_data      (inst_data),
      .pc             (pc),
      .id_instruction (id_instruction),
      .id_pc_plus4    (id_pc_plus4),
      .id_valid       (id_valid)
   );

   // Test program; unmapped addresses read as zero.
   always_comb begin
      case (inst_addr)
         32'h00:  inst_data = 32'h2004_0003;
         32'h04:  inst_data = 32'h0c10_0003;
         32'h08:  inst_data = 32'h1000_ffff;
         32'h0c:  inst_data = 32'h23bd_fff8;
         32'h10:  inst_data = 32'h8fa4_0000;
         32'h14:  inst_data = 32'hafa4_0000;
         32'h18:  inst_data = 32'h03e0_0008;
         default: inst_data = 32'h0000_0000;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      stall = 0; flush = 0; branch_taken = 0; jump = 0; exception = 0;
      branch_target = '0; jump_target = '0;
   endtask

   task automatic test_reset();
      reset = 1;
      clear_events();
      step();
      step();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
      checks++; if (id_instruction !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", id_instruction); end
      checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", id_pc_plus4); end
      reset = 0;
      checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL cycle0_addr: got %h want 0", inst_addr); end
      step();
      checks++; if (id_instruction !== 32'h2004_0003) begin errors++; $display("FAIL e1_inst: got %h want 20040003", id_instruction); end
      checks++; if (id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL e1_pc4: got %h want 4", id_pc_plus4); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL e1_valid: got %b want 1", id_valid); end
      step();
      checks++; if (id_instruction !== 32'h0c10_0003) begin errors++; $display("FAIL e2_inst: got %h want 0c100003", id_instruction); end
      checks++; if (id_pc_plus4 !== 32'h8) begin errors++; $display("FAIL e2_pc4: got %h want 8", id_pc_plus4); end
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL e2_pc: got %h want 8", pc); end
   endtask

   task automatic test_jump();
      jump = 1; jump_target = 32'h0000_000c;
      step();
      clear_events();
      checks++; if (pc !== 32'hc) begin errors++; $display("FAIL jump_pc: got %h want c", pc); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jump_valid: got %b want 0", id_valid); end
      checks++; if (id_instruction !== 32'h0) begin errors++; $display("FAIL jump_inst: got %h want 0", id_instruction); end
      step();
      checks++; if (id_instruction !== 32'h23bd_fff8) begin errors++; $display("FAIL jump_next_inst: got %h want 23bdfff8", id_instruction); end
      checks++; if (id_pc_plus4 !== 32'h10) begin errors++; $display("FAIL jump_next_pc4: got %h want 10", id_pc_plus4); end
   endtask

   task automatic test_stall();
      step();
      checks++; if (pc !== 32'h14) begin errors++; $display("FAIL pre_stall_pc: got %h want 14", pc); end
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (pc !== 32'h14) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 14", i, pc); end
         checks++; if (id_instruction !== 32'h8fa4_0000 || id_pc_plus4 !== 32'h14 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_ifid[%0d]: got %h/%h/%b want 8fa40000/14/1", i, id_instruction, id_pc_plus4, id_valid);
         end
      end
      stall = 0;
      step();
      checks++; if (id_instruction !== 32'hafa4_0000 || id_pc_plus4 !== 32'h18) begin
         errors++; $display("FAIL resume_14: got %h/%h want afa40000/18", id_instruction, id_pc_plus4);
      end
      step();
      checks++; if (id_instruction !== 32'h03e0_0008 || id_pc_plus4 !== 32'h1c) begin
         errors++; $display("FAIL resume_18: got %h/%h want 03e00008/1c", id_instruction, id_pc_plus4);
      end
   endtask

   task automatic test_branch_stall();
      branch_taken = 1; branch_target = 32'h8; stall = 1;
      step();
      clear_events();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL br_stall_pc: got %h want 8", pc); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL br_stall_valid: got %b want 0", id_valid); end
      step();
      checks++; if (id_instruction !== 32'h1000_ffff || id_pc_plus4 !== 32'hc) begin
         errors++; $display("FAIL br_next: got %h/%h want 1000ffff/c", id_instruction, id_pc_plus4);
      end
   endtask

   task automatic test_flush_stall();
      flush = 1; stall = 1;
      step();
      clear_events();
      checks++; if (pc !== 32'hc) begin errors++; $display("FAIL flush_stall_pc: got %h want c", pc); end
      checks++; if (id_valid !== 1'b0 || id_instruction !== 32'h0) begin
         errors++; $display("FAIL flush_stall_ifid: got %h/%b want 0/0", id_instruction, id_valid);
      end
   endtask

   task automatic test_exception();
      exception = 1; branch_taken = 1; branch_target = 32'h8;
      step();
      clear_events();
      checks++; if (pc !== 32'h8000_0008) begin errors++; $display("FAIL exc_pc: got %h want 80000008", pc); end
      checks++; if (id_valid !== 1'b0 || id_pc_plus4 !== 32'h0) begin
         errors++; $display("FAIL exc_ifid: got %h/%b want 0/0", id_pc_plus4, id_valid);
      end
      branch_taken = 1; branch_target = 32'h0000_002f;
      step();
      clear_events();
      checks++; if (pc !== 32'h2c) begin errors++; $display("FAIL align_pc: got %h want 2c", pc); end
   endtask

   task automatic test_reset_mid();
      step();
      stall = 1; jump = 1; jump_target = 32'h40; reset = 1;
      step();
      reset = 0;
      clear_events();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mid_reset_pc: got %h want 0", pc); end
      checks++; if (id_valid !== 1'b0 || id_instruction !== 32'h0) begin
         errors++; $display("FAIL mid_reset_ifid: got %h/%b want 0/0", id_instruction, id_valid);
      end
   endtask

   task automatic test_wrap();
      jump = 1; jump_target = 32'hffff_fffc;
      step();
      clear_events();
      checks++; if (pc !== 32'hffff_fffc) begin errors++; $display("FAIL wrap_setup_pc: got %h want fffffffc", pc); end
      step();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", pc); end
      checks++; if (id_pc_plus4 !== 32'h0 || id_valid !== 1'b1) begin
         errors++; $display("FAIL wrap_ifid: got %h/%b want 0/1", id_pc_plus4, id_valid);
      end
   endtask

   initial begin
      test_reset();
      test_jump();
      test_stall();
      test_branch_stall();
      test_flush_stall();
      test_exception();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline.
- Initiator side of the instruction ROM interface: owns the PC, drives the ROM word address, captures the returned instruction, and loads the IF/ID pipeline register.
- Applies redirects from later stages: branch from EX, jump/jr from ID, exception.
- Applies hazard-unit stall/flush.
- No branch delay slots: any redirect squashes the instruction fetched in the same cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0008, PC loaded on exception.
- NOP_INST, 32'h0000_0000, instruction inserted into IF/ID on flush/squash.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  hazard unit: squash IF/ID contents.
- branch_taken  in  1  EX-stage branch resolved taken.
- branch_target  in  32  EX-stage branch target.
- jump  in  1  ID-stage j/jal/jr/jalr.
- jump_target  in  32  ID-stage jump target (register value for jr).
- exception  in  1  take exception this cycle.
- inst_addr  out  32  byte address to ROM Address; combinationally equal to pc.
- inst_data  in  32  ROM Instruction; combinational, same cycle.
- pc  out  32  current fetch PC.
- id_instruction  out  32  IF/ID instruction.
- id_pc_plus4  out  32  IF/ID PC+4 (link value, branch base).
- id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset: clk and reset as named above; reset is synchronous, active-high, single clock domain. On reset, pc=RESET_PC, id_instruction=NOP_INST, id_pc_plus4=0, id_valid=0. Reset overrides every other input.
- Mid-operation reset behaves the same: the next edge restores all reset values regardless of stall or redirect.
- inst_addr = pc with no register, giving one-cycle fetch latency: the instruction at pc appears in IF/ID after the next edge.
- Next-PC priority, highest first:
  - reset -> RESET_PC
  - exception -> EXC_VECTOR
  - branch_taken -> branch_target
  - jump -> jump_target
  - stall -> pc (hold)
  - otherwise -> pc+4
- Redirect targets: bits [1:0] forced to 00.
- pc+4 arithmetic: 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- IF/ID update priority, highest first:
  - reset
  - exception | branch_taken | jump | flush -> id_instruction=NOP_INST, id_pc_plus4=0, id_valid=0
  - stall -> hold all three
  - otherwise -> id_instruction=inst_data, id_pc_plus4=pc+4, id_valid=1
- Simultaneous events:
  - Redirect with stall: the redirect wins; PC moves and IF/ID is squashed.
  - Flush with stall (no redirect): IF/ID is squashed and PC holds.
  - Exception with branch: the exception wins.
- Unmapped ROM addresses return 0, which is a NOP. No special handling is needed.

Decomposition:
- Shared package (cpu_defs): NOP_INST, RESET_PC, EXC_VECTOR, INST_W=32.
- One combinational sub-module pc_next_sel: implements the priority mux, target alignment and pc+4.
- fetch_stage holds the PC register and the IF/ID register.

Test Plan:
- Reset release with ROM loaded with the test program:
  - cycle0: inst_addr=0.
  - After edge 1: id_instruction=32'h20040003, id_pc_plus4=4, id_valid=1.
  - After edge 2: id_instruction=32'h0c100003, id_pc_plus4=8.
- Jump: with IF/ID holding 32'h0c100003 and pc=8, assert jump with jump_target=32'h0000_000C:
  - Next: pc=C, IF/ID=NOP, id_valid=0.
  - Following edge: id_instruction=32'h23bdfff8, id_pc_plus4=10.
- Stall: assert stall 3 cycles with pc=14:
  - pc and IF/ID stay constant.
  - On release, fetch resumes at 14 (32'hafa40000), then 18.
- Branch with stall: branch_taken=1, branch_target=32'h0000_0008, stall=1 in the same cycle:
  - pc=8, id_valid=0.
  - Next edge: id_instruction=32'h1000ffff.
- Exception with branch_taken in the same cycle: pc=32'h8000_0008, IF/ID squashed.
  - Also: a branch_target of 32'h0000_002F yields pc=2C.
- Reset asserted mid-stall with a pending jump: next edge gives pc=0, id_valid=0, id_instruction=0.
- Wrap: force pc=32'hFFFF_FFFC, no events: next pc=0, id_pc_plus4=0.
